// File: rtl/ar_uid_allocator.sv
// ar_uid_allocator: maps AR original IDs to {row,col} unique IDs and restores them on free.
module ar_uid_allocator #(
    parameter int ID_WIDTH = 32,
    parameter int NUM_ROWS = 16,
    parameter int NUM_COLS = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              alloc_valid,
    input  logic [ID_WIDTH-1:0]               alloc_orig_id,
    output logic                              alloc_ready,
    output logic [ID_WIDTH-1:0]               alloc_uid,
    input  logic                              allocator_free_req,
    input  logic [ID_WIDTH-1:0]               uid_to_restore,
    output logic [ID_WIDTH-1:0]               restored_id,
    output logic [$clog2(NUM_ROWS+1)-1:0]     rows_in_use,
    output logic                              free_err
);
    localparam int COL_W = $clog2(NUM_COLS);
    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam int CNT_W = $clog2(NUM_COLS+1);
    localparam int RIU_W = $clog2(NUM_ROWS+1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_COLS);

    logic [NUM_ROWS-1:0] row_valid;
    logic [ID_WIDTH-1:0] row_orig_id [NUM_ROWS];
    logic [CNT_W-1:0]    row_cnt     [NUM_ROWS];
    logic [COL_W-1:0]    row_tail    [NUM_ROWS];

    logic                hit, free_ok;
    logic [ROW_W-1:0]    hit_row, free_row, sel_row, fr_row;
    logic [NUM_ROWS-1:0] a_sel, f_sel;
    logic                unused_uid_bits;

    assign fr_row          = uid_to_restore[COL_W +: ROW_W];
    assign unused_uid_bits = ^{uid_to_restore[ID_WIDTH-1:COL_W+ROW_W], uid_to_restore[COL_W-1:0]};
    assign sel_row         = hit ? hit_row : free_row;
    assign alloc_ready     = !rst && (hit ? row_cnt[hit_row] < FULL : free_ok);
    assign alloc_uid       = ID_WIDTH'({sel_row, row_tail[sel_row]});
    assign restored_id     = row_orig_id[fr_row];

    // Descending scan leaves the lowest-index free row selected.
    always_comb begin
        hit         = 1'b0;
        hit_row     = '0;
        free_ok     = 1'b0;
        free_row    = '0;
        rows_in_use = '0;
        for (int r = NUM_ROWS-1; r >= 0; r--) begin
            if (row_valid[r] && row_orig_id[r] == alloc_orig_id) begin
                hit     = 1'b1;
                hit_row = ROW_W'(r);
            end
            if (!row_valid[r]) begin
                free_ok  = 1'b1;
                free_row = ROW_W'(r);
            end
            rows_in_use = rows_in_use + RIU_W'(row_valid[r]);
        end
    end

    always_comb begin
        a_sel = '0;
        f_sel = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            a_sel[r] = alloc_valid && alloc_ready && sel_row == ROW_W'(r);
            f_sel[r] = allocator_free_req && fr_row == ROW_W'(r) && row_cnt[r] != '0;
        end
    end

    // Tails survive row release so they stay aligned with the ordering unit's release pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_valid <= '0;
            free_err  <= 1'b0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                row_orig_id[r] <= '0;
                row_cnt[r]     <= '0;
                row_tail[r]    <= '0;
            end
        end else begin
            if (allocator_free_req && row_cnt[fr_row] == '0)
                free_err <= 1'b1;
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (a_sel[r]) begin
                    row_tail[r]    <= row_tail[r] + 1'b1;
                    row_valid[r]   <= 1'b1;
                    row_orig_id[r] <= alloc_orig_id;
                end
                if (a_sel[r] && !f_sel[r])
                    row_cnt[r] <= row_cnt[r] + 1'b1;
                else if (f_sel[r] && !a_sel[r]) begin
                    row_cnt[r] <= row_cnt[r] - 1'b1;
                    if (row_cnt[r] == CNT_W'(1))
                        row_valid[r] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ar_uid_allocator.sv
// tb_ar_uid_allocator: scoreboard bench for ar_uid_allocator.
module tb_ar_uid_allocator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alloc_valid = 1'b0;
    logic [31:0] alloc_orig_id = '0;
    logic        alloc_ready;
    logic [31:0] alloc_uid;
    logic        allocator_free_req = 1'b0;
    logic [31:0] uid_to_restore = '0;
    logic [31:0] restored_id;
    logic [4:0]  rows_in_use;
    logic        free_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb [$];

    ar_uid_allocator dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_orig_id(alloc_orig_id),
        .alloc_ready(alloc_ready), .alloc_uid(alloc_uid),
        .allocator_free_req(allocator_free_req), .uid_to_restore(uid_to_restore),
        .restored_id(restored_id), .rows_in_use(rows_in_use), .free_err(free_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every accepted allocation must match the oldest expected uid.
    always @(negedge clk)
        if (!rst && alloc_valid && alloc_ready) begin
            if (sb.size() == 0) check("uid_unexpected", alloc_uid, 32'hFFFF_FFFF);
            else check("uid", alloc_uid, sb.pop_front());
        end

    task automatic cyc(input logic av, input logic [31:0] aid, input logic fr, input logic [31:0] fu);
        @(posedge clk); #1;
        alloc_valid = av; alloc_orig_id = aid; allocator_free_req = fr; uid_to_restore = fu;
    endtask

    task automatic alloc(input logic [31:0] id, input logic [31:0] uid);
        cyc(1'b1, id, 1'b0, 32'h0);
        sb.push_back(uid);
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; alloc_valid = 1'b0; allocator_free_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'h0, alloc_ready}, 32'h0);
        check("rst_rows", {27'h0, rows_in_use}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_free_err", {31'h0, free_err}, 32'h0);

        // Back-to-back allocs on one ID, then a new ID on the next row.
        alloc(32'h5, 32'h00); alloc(32'h5, 32'h01); alloc(32'h5, 32'h02);
        alloc(32'h9, 32'h10);
        idle(); @(negedge clk);
        check("s1_rows", {27'h0, rows_in_use}, 32'h2);

        // Row full, stays full, free reopens with wrapped tail.
        do_reset();
        for (int i = 0; i < 16; i++) alloc(32'h7, 32'(i));
        cyc(1'b1, 32'h7, 1'b0, 32'h0); @(negedge clk);
        check("s2_full", {31'h0, alloc_ready}, 32'h0);
        cyc(1'b1, 32'h7, 1'b0, 32'h0); @(negedge clk);
        check("s2_full_hold", {31'h0, alloc_ready}, 32'h0);
        cyc(1'b1, 32'h7, 1'b1, 32'h0); @(negedge clk);
        check("s2_no_same_cycle", {31'h0, alloc_ready}, 32'h0);
        check("s2_restore", restored_id, 32'h7);
        alloc(32'h7, 32'h00); @(negedge clk);
        check("s2_reopen", {31'h0, alloc_ready}, 32'h1);
        idle();

        // All rows busy; freed row 3 is reused with its preserved tail.
        do_reset();
        for (int i = 0; i < 16; i++) alloc(32'h100 + 32'(i), 32'(i) << 4);
        cyc(1'b1, 32'h200, 1'b0, 32'h0); @(negedge clk);
        check("s3_no_row", {31'h0, alloc_ready}, 32'h0);
        check("s3_rows16", {27'h0, rows_in_use}, 32'd16);
        cyc(1'b0, 32'h0, 1'b1, 32'h30); @(negedge clk);
        check("s3_restore", restored_id, 32'h103);
        alloc(32'h200, 32'h31); @(negedge clk);
        check("s3_rows15", {27'h0, rows_in_use}, 32'd15);
        idle(); @(negedge clk);
        check("s3_rows16b", {27'h0, rows_in_use}, 32'd16);

        // Same-cycle alloc and free on a row holding one request.
        do_reset();
        alloc(32'hB, 32'h00); alloc(32'hC, 32'h10); alloc(32'hA, 32'h20);
        cyc(1'b1, 32'hA, 1'b1, 32'h20); sb.push_back(32'h21);
        idle(); @(negedge clk);
        check("s4_rows", {27'h0, rows_in_use}, 32'h3);
        cyc(1'b0, 32'h0, 1'b1, 32'h21);
        idle(); @(negedge clk);
        check("s4_released", {27'h0, rows_in_use}, 32'h2);
        check("s4_no_err", {31'h0, free_err}, 32'h0);

        // Combinational restore, and a free to an empty row.
        do_reset();
        alloc(32'h1, 32'h00); alloc(32'hDEAD, 32'h10); alloc(32'hDEAD, 32'h11);
        cyc(1'b0, 32'h0, 1'b0, 32'h12); @(negedge clk);
        check("s5_restore", restored_id, 32'hDEAD);
        cyc(1'b0, 32'h0, 1'b1, 32'h10); @(negedge clk);
        check("s5_restore_free", restored_id, 32'hDEAD);
        cyc(1'b0, 32'h0, 1'b1, 32'h50);
        idle(); @(negedge clk);
        check("s5_free_err", {31'h0, free_err}, 32'h1);
        check("s5_rows", {27'h0, rows_in_use}, 32'h2);
        alloc(32'hDEAD, 32'h12); alloc(32'h77, 32'h20);
        idle(); @(negedge clk);
        check("s5_sticky", {31'h0, free_err}, 32'h1);

        // Async reset mid-traffic clears rows and tails.
        do_reset();
        for (int i = 1; i <= 5; i++) alloc(32'(i), 32'(i-1) << 4);
        alloc(32'h1, 32'h01);
        idle(); @(negedge clk);
        check("s6_rows5", {27'h0, rows_in_use}, 32'h5);
        rst = 1'b1; #1;
        check("s6_async_rows", {27'h0, rows_in_use}, 32'h0);
        check("s6_async_ready", {31'h0, alloc_ready}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        alloc(32'h3, 32'h00);
        idle(); @(negedge clk);
        check("s6_rows1", {27'h0, rows_in_use}, 32'h1);

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ar_uid_allocator.md
Name: ar_uid_allocator

Overview:
- Read-address-side ID allocator for the reorder block.
- On each accepted AR request it maps the original AXI ID to a unique ID (uid) = {row, col}. All requests with the same original ID share one row. Successive requests on that row take successive columns.
- On free requests from the R ordering unit it restores the original ID and retires the uid.
- It owns the uid space and shares it between concurrent original IDs. Its column sequence per row is exactly the sequence the ordering unit's per-row release pointer follows.

Parameters:
- ID_WIDTH, 32: width of original IDs and of the zero-extended uid.
- NUM_ROWS, 16: number of distinct original IDs outstanding at once (power of 2).
- NUM_COLS, 16: max outstanding requests per row (power of 2). Column pointer width COL_W = clog2(NUM_COLS).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- alloc_valid  in  1  AR request presents alloc_orig_id.
- alloc_orig_id  in  ID_WIDTH  original ID of the request.
- alloc_ready  out  1  allocation can be accepted this cycle.
- alloc_uid  out  ID_WIDTH  {row,col} zero-extended; valid when alloc_valid & alloc_ready.
- allocator_free_req  in  1  retire uid_to_restore (last R beat sent).
- uid_to_restore  in  ID_WIDTH  uid to look up / retire.
- restored_id  out  ID_WIDTH  original ID for uid_to_restore (combinational).
- rows_in_use  out  clog2(NUM_ROWS+1)  number of valid rows.
- free_err  out  1  sticky: free issued to a row with zero outstanding.

Behaviour:
- State per row:
  - row_valid
  - row_orig_id[ID_WIDTH]
  - row_cnt[clog2(NUM_COLS+1)] (0..NUM_COLS)
  - row_tail[COL_W]
- Reset (async, immediate):
  - all row_valid=0, row_cnt=0, row_tail=0, row_orig_id=0, free_err=0.
  - Outputs during rst: alloc_ready=0, rows_in_use=0.
- Lookup, combinational from registered state:
  - hit = some valid row with row_orig_id==alloc_orig_id. At most one row can match (invariant).
  - free_row = lowest-index row with row_valid=0.
- alloc_ready:
  - hit: ready = (row_cnt[hit] < NUM_COLS).
  - no hit: ready = (a free row exists).
  - Independent of allocator_free_req in the same cycle; no same-cycle reuse of freed capacity.
- alloc_uid:
  - hit: {hit_row, row_tail[hit_row]}.
  - no hit: {free_row, row_tail[free_row]}.
  - Upper bits are zero.
- Allocation commits on alloc_valid & alloc_ready at the clock edge:
  - row_tail+1, wrapping NUM_COLS-1 -> 0.
  - row_cnt+1.
  - On a new row: row_valid=1 and row_orig_id=alloc_orig_id.
- row_tail is never cleared on row release. It must stay aligned with the ordering unit's release pointer, which also persists.
- restored_id = row_orig_id[uid_to_restore row field], purely combinational. It must be correct in the same cycle allocator_free_req is high.
- Free commits on allocator_free_req at the clock edge:
  - row_cnt-1.
  - If the result is 0 and there is no same-cycle allocation to that row, row_valid=0.
  - Frees arrive per row in column order; the column field is not checked.
  - Free to a row with row_cnt=0: no state change, free_err set until reset.
- Simultaneous alloc and free on the same row: row_cnt unchanged, tail advances, row stays valid even if the pre-edge count was 1.
- Simultaneous alloc to row A and free of row B: both applied independently.
- Row freed at edge N is allocatable to a new ID from cycle N+1.
- rows_in_use = popcount(row_valid), registered-state based.
- No combinational path from allocator_free_req to alloc_ready or alloc_uid.

Test Plan:
- After reset: alloc ID 0x5 three times back-to-back -> uids 0x00,0x01,0x02. Then ID 0x9 -> uid 0x10. rows_in_use=2.
- Alloc ID 0x7 16 times -> uids 0x00..0x0F. 17th request -> alloc_ready=0 and stays 0. One free -> alloc_ready=1 next cycle; next uid 0x00 (tail wrap).
- Fill all 16 rows with IDs 0x100..0x10F (one each); ID 0x200 -> alloc_ready=0. Free uid 0x30 (row 3) -> row 3 invalid; ID 0x200 accepted next cycle with uid 0x31 (tail preserved).
- Row 2 holds ID 0xA, cnt=1. Same cycle: free uid 0x20 plus alloc ID 0xA -> uid 0x21, row 2 still valid, cnt=1, rows_in_use unchanged.
- uid_to_restore=0x12 with row 1 holding 0xDEAD -> restored_id=0xDEAD in the same cycle. Free to a row with cnt=0 -> free_err=1, no other state change.
- Assert rst mid-traffic with 5 rows active -> immediately all rows invalid, alloc_ready=0 while in reset. After release, first alloc of any ID -> uid 0x00.
